// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and default sizing for the execute-stage writeback collector.
// FU channel numbering is fixed so that wb_src_o can be decoded by the scoreboard.
package fu_wb_arbiter_pkg;

  localparam int TRANS_ID_BITS   = 3;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_NR_WB_PORTS = 2;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_BRANCH = 3'd1,
    FU_LSU    = 3'd2,
    FU_CSR    = 3'd3,
    FU_MULT   = 3'd4
  } fu_idx_e;

  localparam int DEF_NR_FU = int'(FU_MULT) + 1;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] result;
    logic [TRANS_ID_BITS-1:0]  trans_id;
    logic                      ex_valid;
  } wb_entry_t;

endpackage

// File: rtl/fu_wb_arbiter_fifo.sv
// Per-unit result buffer: a plain DEPTH-entry circular FIFO with a synchronous flush.
// The read data is combinational from the head entry; there is no fall-through path.
module wb_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           data_i,
  input  logic             pop_i,
  output entry_t           data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback collector: buffers each functional unit's results and drains up to
// NR_WB_PORTS of them per cycle onto registered ports with a round-robin scan.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int  NR_FU       = DEF_NR_FU,
  parameter int  NR_WB_PORTS = DEF_NR_WB_PORTS,
  parameter int  DEPTH       = 2,
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int SRC_W       = (NR_FU > 1) ? $clog2(NR_FU) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NR_FU-1:0]                       fu_valid_i,
  output logic [NR_FU-1:0]                       fu_ready_o,
  input  logic [NR_FU*DATA_WIDTH-1:0]            fu_result_i,
  input  logic [NR_FU*TRANS_ID_BITS-1:0]         fu_trans_id_i,
  input  logic [NR_FU-1:0]                       fu_ex_valid_i,
  output logic [NR_WB_PORTS-1:0]                 wb_valid_o,
  output logic [NR_WB_PORTS*DATA_WIDTH-1:0]      wb_result_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0]                 wb_ex_valid_o,
  output logic [NR_WB_PORTS*SRC_W-1:0]           wb_src_o
);

  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [SRC_W-1:0] LAST_FU  = SRC_W'(NR_FU - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     ex_valid;
  } entry_t;

  entry_t           fu_entry   [NR_FU];
  entry_t           fifo_out   [NR_FU];
  logic [CNT_W-1:0] fifo_count [NR_FU];
  logic [NR_FU-1:0] fifo_full, fifo_empty, pop;

  logic [NR_WB_PORTS-1:0] port_valid;
  logic [SRC_W-1:0]       port_src   [NR_WB_PORTS];
  entry_t                 port_entry [NR_WB_PORTS];
  logic [SRC_W-1:0]       rr_q, rr_next, idx;
  logic [SRC_W:0]         sum;
  int                     gcnt;

  logic [NR_WB_PORTS-1:0] wb_valid_q;
  logic [SRC_W-1:0]       wb_src_q   [NR_WB_PORTS];
  entry_t                 wb_entry_q [NR_WB_PORTS];

  for (genvar i = 0; i < NR_FU; i++) begin : g_chan
    assign fu_entry[i] = '{result:   fu_result_i[i*DATA_WIDTH +: DATA_WIDTH],
                           trans_id: fu_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS],
                           ex_valid: fu_ex_valid_i[i]};
    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign fu_ready_o[i] = (fifo_count[i] != CNT_FULL);

    wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (fu_valid_i[i] & ~fifo_full[i] & ~flush_i),
      .data_i  (fu_entry[i]),
      .pop_i   (pop[i]),
      .data_o  (fifo_out[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pop        = '0;
    port_valid = '0;
    rr_next    = rr_q;
    sum        = '0;
    idx        = '0;
    gcnt       = 0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      port_src[p]   = '0;
      port_entry[p] = '0;
    end
    for (int k = 0; k < NR_FU; k++) begin
      sum = {1'b0, rr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NR_FU)) sum = sum - (SRC_W+1)'(NR_FU);
      idx = sum[SRC_W-1:0];
      if (!fifo_empty[idx] && gcnt < NR_WB_PORTS) begin
        for (int p = 0; p < NR_WB_PORTS; p++) begin
          if (p == gcnt) begin
            port_valid[p] = 1'b1;
            port_src[p]   = idx;
            port_entry[p] = fifo_out[idx];
          end
        end
        pop[idx] = 1'b1;
        rr_next  = (idx == LAST_FU) ? '0 : idx + 1'b1;
        gcnt     = gcnt + 1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      wb_valid_q <= '0;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        wb_src_q[p]   <= '0;
        wb_entry_q[p] <= '0;
      end
    end else if (flush_i) begin
      rr_q       <= '0;
      wb_valid_q <= '0;
    end else begin
      rr_q       <= rr_next;
      wb_valid_q <= port_valid;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (port_valid[p]) begin
          wb_src_q[p]   <= port_src[p];
          wb_entry_q[p] <= port_entry[p];
        end
      end
    end
  end

  assign wb_valid_o = wb_valid_q;
  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
    assign wb_result_o[p*DATA_WIDTH +: DATA_WIDTH]         = wb_entry_q[p].result;
    assign wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = wb_entry_q[p].trans_id;
    assign wb_ex_valid_o[p]                                = wb_entry_q[p].ex_valid;
    assign wb_src_o[p*SRC_W +: SRC_W]                      = wb_src_q[p];
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Scoreboard bench for fu_wb_arbiter: a queue-based reference predicts every writeback
// port each cycle, and per-scenario tasks add targeted checks on latency, order and flush.
module tb_fu_wb_arbiter;

  localparam int NR_FU = 5;
  localparam int NR_WB = 2;
  localparam int DEPTH = 2;
  localparam int DW    = 64;
  localparam int TID   = 3;
  localparam int SW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  flush;
  logic [NR_FU-1:0]      fu_valid;
  logic [NR_FU-1:0]      fu_ready_o;
  logic [NR_FU*DW-1:0]   fu_result;
  logic [NR_FU*TID-1:0]  fu_trans_id;
  logic [NR_FU-1:0]      fu_ex;
  logic [NR_WB-1:0]      wb_valid_o;
  logic [NR_WB*DW-1:0]   wb_result_o;
  logic [NR_WB*TID-1:0]  wb_trans_id_o;
  logic [NR_WB-1:0]      wb_ex_valid_o;
  logic [NR_WB*SW-1:0]   wb_src_o;

  always #5 clk = ~clk;

  fu_wb_arbiter #(.NR_FU(NR_FU), .NR_WB_PORTS(NR_WB), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .fu_valid_i    (fu_valid),
    .fu_ready_o    (fu_ready_o),
    .fu_result_i   (fu_result),
    .fu_trans_id_i (fu_trans_id),
    .fu_ex_valid_i (fu_ex),
    .wb_valid_o    (wb_valid_o),
    .wb_result_o   (wb_result_o),
    .wb_trans_id_o (wb_trans_id_o),
    .wb_ex_valid_o (wb_ex_valid_o),
    .wb_src_o      (wb_src_o)
  );

  typedef struct packed {
    logic [DW-1:0]  result;
    logic [TID-1:0] id;
    logic           ex;
    logic [SW-1:0]  src;
  } ent_t;

  typedef struct packed {
    logic valid;
    ent_t e;
  } exp_t;

  ent_t             mq [NR_FU][$];
  exp_t             exp_q[$];
  logic [DW-1:0]    seen4[$];
  int               rr;
  logic [NR_FU-1:0] acc;
  int               checks = 0;
  int               failures = 0;

  function automatic ent_t dut_port(int p);
    ent_t e;
    e.result = wb_result_o[p*DW +: DW];
    e.id     = wb_trans_id_o[p*TID +: TID];
    e.ex     = wb_ex_valid_o[p];
    e.src    = wb_src_o[p*SW +: SW];
    return e;
  endfunction

  task automatic clear_inputs();
    fu_valid    = '0;
    fu_result   = '0;
    fu_trans_id = '0;
    fu_ex       = '0;
    flush       = 1'b0;
  endtask

  task automatic set_fu(int i, logic v, logic [DW-1:0] r, logic [TID-1:0] id, logic ex);
    fu_valid[i]              = v;
    fu_result[i*DW +: DW]    = r;
    fu_trans_id[i*TID +: TID] = id;
    fu_ex[i]                 = ex;
  endtask

  // One clock: predict this cycle's grants and pushes, step the clock, compare every port.
  task automatic tick();
    logic [NR_FU-1:0] mready;
    int   g, last, idx;
    ent_t e, got;
    exp_t x;
    for (int i = 0; i < NR_FU; i++) mready[i] = (mq[i].size() < DEPTH);
    checks++;
    if (fu_ready_o !== mready) begin
      failures++;
      $display("FAIL fu_ready: got %b expected %b", fu_ready_o, mready);
    end
    acc = '0;
    if (flush) begin
      for (int i = 0; i < NR_FU; i++) mq[i].delete();
      rr = 0;
      x  = '0;
      for (int p = 0; p < NR_WB; p++) exp_q.push_back(x);
    end else begin
      g    = 0;
      last = -1;
      for (int k = 0; k < NR_FU; k++) begin
        idx = (rr + k) % NR_FU;
        if (mq[idx].size() > 0 && g < NR_WB) begin
          x.valid = 1'b1;
          x.e     = mq[idx].pop_front();
          exp_q.push_back(x);
          last = idx;
          g++;
        end
      end
      if (last >= 0) rr = (last + 1) % NR_FU;
      x = '0;
      for (int p = g; p < NR_WB; p++) exp_q.push_back(x);
      for (int i = 0; i < NR_FU; i++) begin
        if (fu_valid[i] && mready[i]) begin
          e.result = fu_result[i*DW +: DW];
          e.id     = fu_trans_id[i*TID +: TID];
          e.ex     = fu_ex[i];
          e.src    = SW'(i);
          mq[i].push_back(e);
          acc[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR_WB; p++) begin
      x   = exp_q.pop_front();
      got = dut_port(p);
      checks++;
      if (wb_valid_o[p] !== x.valid) begin
        failures++;
        $display("FAIL wb_valid[%0d]: got %b expected %b", p, wb_valid_o[p], x.valid);
      end else if (x.valid) begin
        checks++;
        if (got !== x.e) begin
          failures++;
          $display("FAIL wb_port%0d: got %h expected %h", p, got, x.e);
        end
      end
      if (wb_valid_o[p] === 1'b1 && got.src == SW'(4)) seen4.push_back(got.result);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_valid_o !== '0) begin
      failures++;
      $display("FAIL async_reset_valid: got %b expected 0", wb_valid_o);
    end
    for (int i = 0; i < NR_FU; i++) mq[i].delete();
    exp_q.delete();
    rr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fu_ready_o !== '1 || wb_valid_o !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b valid=%b expected ready=11111 valid=00", fu_ready_o, wb_valid_o);
    end
    checks++;
    if (wb_result_o !== '0 || wb_trans_id_o !== '0 || wb_ex_valid_o !== '0 || wb_src_o !== '0) begin
      failures++;
      $display("FAIL reset_data: result=%h id=%h ex=%b src=%h expected all 0",
               wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_src_o);
    end
  endtask

  task automatic test_single();
    clear_inputs();
    set_fu(2, 1'b1, 64'hDEAD, 3'd3, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (wb_valid_o !== 2'b00) begin
      failures++;
      $display("FAIL single_no_fallthrough: got %b expected 00", wb_valid_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 2'b01 || wb_result_o[DW-1:0] !== 64'hDEAD ||
        wb_trans_id_o[TID-1:0] !== 3'd3 || wb_src_o[SW-1:0] !== 3'd2) begin
      failures++;
      $display("FAIL single_latency2: valid=%b result=%h id=%0d src=%0d expected 01 dead 3 2",
               wb_valid_o, wb_result_o[DW-1:0], wb_trans_id_o[TID-1:0], wb_src_o[SW-1:0]);
    end
  endtask

  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 64'h5000 + DW'(i), TID'(i), 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_src_o !== {3'd1, 3'd0}) begin
      failures++;
      $display("FAIL rr_round1: valid=%b src=%h expected 11 src1=1 src0=0", wb_valid_o, wb_src_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_src_o !== {3'd3, 3'd2}) begin
      failures++;
      $display("FAIL rr_round2: valid=%b src=%h expected 11 src1=3 src0=2", wb_valid_o, wb_src_o);
    end
    set_fu(0, 1'b1, 64'h6000, 3'd0, 1'b0);
    set_fu(4, 1'b1, 64'h6004, 3'd4, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_src_o !== {3'd0, 3'd4}) begin
      failures++;
      $display("FAIL rr_ptr_at_4: valid=%b src=%h expected 11 src1=0 src0=4", wb_valid_o, wb_src_o);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] val [4];
    logic [DW-1:0] v4  [3];
    int n4;
    bit drop_checked;
    do_reset();
    seen4.delete();
    n4 = 0;
    drop_checked = 1'b0;
    for (int i = 0; i < 4; i++) val[i] = DW'(64'h100 * (i + 1));
    v4[0] = 64'hA0;
    v4[1] = 64'hA1;
    v4[2] = 64'hA2;
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int i = 0; i < 4; i++) set_fu(i, cyc < 20, val[i], TID'(i), 1'b0);
      if (n4 < 3) set_fu(4, 1'b1, v4[n4], 3'd4, 1'b0);
      else        set_fu(4, 1'b0, '0, 3'd0, 1'b0);
      if (n4 == 2 && !drop_checked) begin
        drop_checked = 1'b1;
        checks++;
        if (fu_ready_o[4] !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_drop: got %b expected 0 after two pushes", fu_ready_o[4]);
        end
      end
      tick();
      for (int i = 0; i < 4; i++) if (acc[i]) val[i] = val[i] + 1;
      if (acc[4]) n4++;
    end
    clear_inputs();
    checks++;
    if (n4 != 3) begin
      failures++;
      $display("FAIL bp_accepted: got %0d expected 3", n4);
    end
    checks++;
    if (seen4.size() != 3 || seen4[0] !== 64'hA0 || seen4[1] !== 64'hA1 || seen4[2] !== 64'hA2) begin
      failures++;
      $display("FAIL bp_order: got %0d writebacks expected a0,a1,a2 in order", seen4.size());
    end
  endtask

  task automatic test_ex();
    clear_inputs();
    set_fu(1, 1'b1, 64'h77, 3'd7, 1'b1);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (wb_valid_o[0] !== 1'b1 || wb_ex_valid_o[0] !== 1'b1 || wb_trans_id_o[TID-1:0] !== 3'd7) begin
      failures++;
      $display("FAIL ex_valid: valid=%b ex=%b id=%0d expected 1 1 7",
               wb_valid_o[0], wb_ex_valid_o[0], wb_trans_id_o[TID-1:0]);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    set_fu(0, 1'b1, 64'h11, 3'd1, 1'b0);
    set_fu(1, 1'b1, 64'h22, 3'd2, 1'b0);
    set_fu(2, 1'b1, 64'h33, 3'd3, 1'b0);
    tick();
    clear_inputs();
    flush = 1'b1;
    set_fu(4, 1'b1, 64'h44, 3'd4, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (wb_valid_o !== 2'b00 || fu_ready_o !== '1) begin
      failures++;
      $display("FAIL flush_clear: valid=%b ready=%b expected 00 11111", wb_valid_o, fu_ready_o);
    end
    set_fu(3, 1'b1, 64'h55, 3'd5, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (wb_valid_o !== 2'b00) begin
      failures++;
      $display("FAIL flush_no_stale: got %b expected 00", wb_valid_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 2'b01 || wb_result_o[DW-1:0] !== 64'h55 || wb_src_o[SW-1:0] !== 3'd3) begin
      failures++;
      $display("FAIL flush_post_push: valid=%b result=%h src=%0d expected 01 55 3",
               wb_valid_o, wb_result_o[DW-1:0], wb_src_o[SW-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    for (int i = 0; i < NR_FU; i++) set_fu(i, 1'b1, 64'h9000 + DW'(i), TID'(i), 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (wb_valid_o !== 2'b11) begin
      failures++;
      $display("FAIL mid_drain_busy: got %b expected 11", wb_valid_o);
    end
    #2;
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (fu_ready_o !== '1) begin
      failures++;
      $display("FAIL mid_reset_ready: got %b expected 11111", fu_ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_ex();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
